sram_rw_valrdy_adapter: RTL

Parametrised latency-insensitive front end for a single-port (1rw) SRAM macro. It accepts val/rdy read and write requests, supports byte-masked writes via an internal read-modify-write sequence, and returns in-order responses through a response queue with backpressure. The block sits between cache/memory controllers and a sram_SramGeneric-style instance of any width and depth. It is the successor to the fixed 128x256 full-word wrapper.

---
 rtl/sram_rw_valrdy_adapter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sram_rw_valrdy_adapter.sv
// sram_rw_valrdy_adapter: val/rdy front end for a single-port SRAM.
// Accepts read and byte-masked write requests, turns partial writes into a
// two-cycle read-modify-write, and returns in-order responses through a small
// response FIFO. Out-of-range addresses never touch the array.
module sram_rw_valrdy_adapter #(
   parameter  int p_data_nbits   = 128,
   parameter  int p_num_entries  = 256,
   parameter  int p_opaque_nbits = 8,
   parameter  int p_resp_depth   = 3,
   localparam int c_addr_nbits   = (p_num_entries > 1) ? $clog2(p_num_entries) : 1,
   localparam int c_mask_nbits   = p_data_nbits / 8
) (
   input  logic                      clk0,
   input  logic                      rst0_n,
   input  logic                      req_val,
   output logic                      req_rdy,
   input  logic                      req_type,
   input  logic [p_opaque_nbits-1:0] req_opaque,
   input  logic [c_addr_nbits-1:0]   req_addr,
   input  logic [c_mask_nbits-1:0]   req_wmask,
   input  logic [p_data_nbits-1:0]   req_data,
   output logic                      resp_val,
   input  logic                      resp_rdy,
   output logic                      resp_type,
   output logic [p_opaque_nbits-1:0] resp_opaque,
   output logic [p_data_nbits-1:0]   resp_data
);

   localparam int c_ptr_nbits = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;
   localparam int c_cnt_nbits = $clog2(p_resp_depth + 1);

   // Widened by one bit so a power-of-two entry count does not truncate to 0.
   localparam logic [c_addr_nbits:0]   c_num_entries = (c_addr_nbits + 1)'(p_num_entries);
   localparam logic [c_cnt_nbits:0]    c_depth       = (c_cnt_nbits + 1)'(p_resp_depth);
   localparam logic [c_ptr_nbits-1:0]  c_ptr_last    = c_ptr_nbits'(p_resp_depth - 1);
   localparam logic [c_mask_nbits-1:0] c_mask_full   = '1;

   typedef enum logic {
      IDLE = 1'b0,
      RMW  = 1'b1
   } state_t;

   // Byte enables widened to one bit per data bit.
   function automatic logic [p_data_nbits-1:0] expand_mask(input logic [c_mask_nbits-1:0] m);
      logic [p_data_nbits-1:0] r;
      r = '0;
      for (int i = 0; i < c_mask_nbits; i++) r[8*i +: 8] = {8{m[i]}};
      return r;
   endfunction

   // Keep old bytes where the mask is clear, take new bytes where it is set.
   function automatic logic [p_data_nbits-1:0] merge_bytes(
      input logic [p_data_nbits-1:0] old_word,
      input logic [p_data_nbits-1:0] new_word,
      input logic [c_mask_nbits-1:0] m
   );
      logic [p_data_nbits-1:0] bm;
      bm = expand_mask(m);
      return (old_word & ~bm) | (new_word & bm);
   endfunction

   state_t                    state;
   logic                      req_fire;
   logic                      resp_fire;
   logic                      oor_p0;
   logic                      partial_p0;

   logic                      vld_p1;
   logic                      type_p1;
   logic [p_opaque_nbits-1:0] opaque_p1;
   logic [c_addr_nbits-1:0]   addr_p1;
   logic [p_data_nbits-1:0]   data_p1;
   logic [c_mask_nbits-1:0]   wmask_p1;
   logic                      oor_p1;
   logic [p_data_nbits-1:0]   dout_p1;
   logic [p_data_nbits-1:0]   enq_data_p1;

   logic                      sram_en;
   logic                      sram_we;
   logic [c_addr_nbits-1:0]   sram_addr;
   logic [p_data_nbits-1:0]   sram_wdata;
   logic [p_data_nbits-1:0]   mem [p_num_entries];

   logic                      q_type   [p_resp_depth];
   logic [p_opaque_nbits-1:0] q_opaque [p_resp_depth];
   logic [p_data_nbits-1:0]   q_data   [p_resp_depth];
   logic [c_ptr_nbits-1:0]    wr_ptr;
   logic [c_ptr_nbits-1:0]    rd_ptr;
   logic [c_cnt_nbits-1:0]    q_count;

   // Stage 0: request acceptance. Space is reserved for the in-flight stage-1
   // response so the queue can never overflow, without looking at resp_rdy.
   assign oor_p0     = ({1'b0, req_addr} >= c_num_entries);
   assign partial_p0 = req_type && (req_wmask != '0) && (req_wmask != c_mask_full);
   assign req_rdy    = rst0_n && (state == IDLE) &&
                       (({1'b0, q_count} + {{c_cnt_nbits{1'b0}}, vld_p1}) < c_depth);
   assign req_fire   = req_val && req_rdy;

   // SRAM port steering: the RMW write-back owns the port, otherwise the firing request.
   always_comb begin
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = req_addr;
      sram_wdata = req_data;
      if (state == RMW) begin
         sram_en    = !oor_p1;
         sram_we    = 1'b1;
         sram_addr  = addr_p1;
         sram_wdata = merge_bytes(dout_p1, data_p1, wmask_p1);
      end else if (req_fire && !oor_p0) begin
         if (!req_type) begin
            sram_en = 1'b1;
         end else if (req_wmask == c_mask_full) begin
            sram_en = 1'b1;
            sram_we = 1'b1;
         end else if (req_wmask != '0) begin
            sram_en = 1'b1;
         end
      end
   end

   // Single-port array with synchronous read; dout holds until the next read.
   always_ff @(posedge clk0) begin
      if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
      if (sram_en && !sram_we) dout_p1 <= mem[sram_addr];
   end

   // Stage 1 data capture: request fields needed for the response and the RMW merge.
   always_ff @(posedge clk0) begin
      if (req_fire) begin
         type_p1   <= req_type;
         opaque_p1 <= req_opaque;
         addr_p1   <= req_addr;
         data_p1   <= req_data;
         wmask_p1  <= req_wmask;
         oor_p1    <= oor_p0;
      end
   end

   // Control FSM: partial writes spend one extra cycle in RMW writing the merged word.
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         state  <= IDLE;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= req_fire;
         case (state)
            IDLE:    if (req_fire && partial_p0) state <= RMW;
            RMW:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Stage 1 -> queue: writes and out-of-range reads return zero data.
   assign enq_data_p1 = (type_p1 || oor_p1) ? '0 : dout_p1;

   // Response FIFO storage.
   always_ff @(posedge clk0) begin
      if (vld_p1) begin
         q_type[wr_ptr]   <= type_p1;
         q_opaque[wr_ptr] <= opaque_p1;
         q_data[wr_ptr]   <= enq_data_p1;
      end
   end

   // Response FIFO pointers and occupancy; wrap is explicit for non-power-of-two depths.
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_count <= '0;
      end else begin
         if (vld_p1)    wr_ptr <= (wr_ptr == c_ptr_last) ? '0 : wr_ptr + c_ptr_nbits'(1);
         if (resp_fire) rd_ptr <= (rd_ptr == c_ptr_last) ? '0 : rd_ptr + c_ptr_nbits'(1);
         case ({vld_p1, resp_fire})
            2'b10:   q_count <= q_count + c_cnt_nbits'(1);
            2'b01:   q_count <= q_count - c_cnt_nbits'(1);
            default: q_count <= q_count;
         endcase
      end
   end

   assign resp_val    = (q_count != '0);
   assign resp_fire   = resp_val && resp_rdy;
   assign resp_type   = q_type[rd_ptr];
   assign resp_opaque = q_opaque[rd_ptr];
   assign resp_data   = q_data[rd_ptr];

endmodule
